// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the CPU MEM stage
// and a debug/IO requester. The CPU normally wins; a pending debug access is
// deferred at most MAX_WAIT consecutive cycles before it preempts the CPU for
// one cycle, stalling any CPU access presented in that cycle.
//
// Optional feature: define DMEM_ARB_STATS_EN to build a saturating count of
// CPU stall cycles on stall_count; otherwise stall_count is tied to zero.
//
// Debug handshake: dbg_req is a level held by the requester until it sees
// dbg_done. The access happens in the cycle dbg_gnt is high; dbg_done pulses
// in the following cycle, so at most one debug access completes every two
// cycles. Dropping dbg_req before the grant abandons the request silently.

module dmem_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    input  logic        cpu_write,
    input  logic        cpu_read,
    output logic [15:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dbg_req,
    input  logic [15:0] dbg_addr,
    input  logic [15:0] dbg_wdata,
    input  logic        dbg_we,
    output logic        dbg_gnt,
    output logic        dbg_done,
    output logic [15:0] dbg_rdata,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [15:0] mem_rdata,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] MAX_WAIT_L = 3'(MAX_WAIT);

    state_t     state;
    state_t     state_next;
    logic [2:0] wait_cnt;
    logic [2:0] wait_cnt_next;
    logic       grant_raw;
    logic       done_raw;
    logic       cpu_req;

    assign cpu_req = cpu_read | cpu_write;

    // Next-state and grant decision; the CPU wins until the wait limit is hit.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        grant_raw     = 1'b0;
        done_raw      = 1'b0;
        case (state)
            IDLE: begin
                if (dbg_req) begin
                    if (!cpu_req) begin
                        grant_raw  = 1'b1;
                        state_next = DONE;
                    end else begin
                        wait_cnt_next = 3'd1;
                        state_next    = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!dbg_req) begin
                    wait_cnt_next = 3'd0;
                    state_next    = IDLE;
                end else if (!cpu_req || (wait_cnt == MAX_WAIT_L)) begin
                    grant_raw  = 1'b1;
                    state_next = DONE;
                end else begin
                    wait_cnt_next = wait_cnt + 3'd1;
                end
            end
            DONE: begin
                done_raw      = 1'b1;
                wait_cnt_next = 3'd0;
                state_next    = IDLE;
            end
            default: begin
                wait_cnt_next = 3'd0;
                state_next    = IDLE;
            end
        endcase
    end

    // Reset masks grant/done so a reset cycle never touches memory or pulses.
    assign dbg_gnt   = grant_raw & ~reset;
    assign dbg_done  = done_raw & ~reset;
    assign cpu_stall = dbg_gnt & cpu_req;
    assign cpu_rdata = mem_rdata;

    // Memory port mux: debug owns the port only in its grant cycle.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_write = cpu_write & ~reset;
        mem_read  = cpu_read & ~reset;
        if (dbg_gnt) begin
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            mem_write = dbg_we;
            mem_read  = ~dbg_we;
        end
    end

    // State register, wait counter and captured debug read data.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= 3'd0;
            dbg_rdata <= 16'h0000;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (dbg_gnt && !dbg_we) begin
                dbg_rdata <= mem_rdata;
            end
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stall_cnt_q;

    // Saturating count of cycles in which the CPU was held off.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q <= 16'h0000;
        end else if (cpu_stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'h0001;
        end
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = 16'h0000;
`endif

endmodule
